// File: rtl/wb_arbiter_marocchino_pkg.sv
// Shared constants for the MAROCCHINO write-back arbiter: unit indices,
// default requester count and arbiter state encoding.
package wb_arbiter_marocchino_pkg;

    localparam int WB_UNIT_ALU = 0;
    localparam int WB_UNIT_MUL = 1;
    localparam int WB_UNIT_DIV = 2;
    localparam int WB_UNIT_LSU = 3;

    localparam int WB_NUM_REQ_DEFAULT = 4;

    typedef enum logic {
        ARB_S  = 1'b0,
        HALT_S = 1'b1
    } wb_arb_state_e;

endpackage

// File: rtl/rr_pick_marocchino.sv
// Combinational round-robin picker: one-hot grant for the first request found
// above the pointer, wrapping modulo NUM_REQ.
module rr_pick_marocchino #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        // Offset NUM_REQ lands back on the pointer itself, so a lone requester
        // can be granted on consecutive cycles.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_marocchino.sv
// Write-back port arbiter: round-robin among execution units, exceptions win
// outright and halt granting until the pipeline is flushed.
module wb_arbiter_marocchino
    import wb_arbiter_marocchino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_REQ              = WB_NUM_REQ_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    pipeline_flush_i,
    input  logic                                    wb_stall_i,
    input  logic [NUM_REQ-1:0]                      req_i,
    input  logic [NUM_REQ-1:0]                      except_i,
    input  logic [NUM_REQ-1:0]                      rf_wb_i,
    input  logic [NUM_REQ*OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_i,
    input  logic [NUM_REQ*OPTION_OPERAND_WIDTH-1:0] result_i,
    output logic [NUM_REQ-1:0]                      grant_o,
    output logic                                    wb_valid_o,
    output logic [NUM_REQ-1:0]                      wb_sel_o,
    output logic                                    wb_rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]         wb_rfd_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]         wb_result_o,
    output logic                                    wb_except_o,
    output logic                                    halted_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int W     = OPTION_OPERAND_WIDTH;
    localparam int A     = OPTION_RF_ADDR_WIDTH;

    wb_arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [NUM_REQ-1:0]   sel_q, sel_d;
    logic                 rf_wb_q, rf_wb_d;
    logic [A-1:0]         adr_q, adr_d;
    logic [W-1:0]         result_q, result_d;
    logic                 except_q, except_d;

    logic [NUM_REQ-1:0]   rr_gnt;
    logic [NUM_REQ-1:0]   exc_req;
    logic [NUM_REQ-1:0]   exc_gnt;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     g_idx;
    logic                 grant_en;
    logic                 grant_exc;

    rr_pick_marocchino #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    assign exc_req  = req_i & except_i;
    assign grant_en = (state_q == ARB_S) && !wb_stall_i && !pipeline_flush_i && (|req_i);

    // Lowest-index excepting request wins regardless of the pointer.
    always_comb begin
        logic found;
        exc_gnt = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && exc_req[i]) begin
                exc_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign grant     = !grant_en ? '0 : ((|exc_req) ? exc_gnt : rr_gnt);
    assign grant_exc = |(grant & except_i);
    assign grant_o   = grant;

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        sel_d    = sel_q;
        rf_wb_d  = rf_wb_q;
        adr_d    = adr_q;
        result_d = result_q;
        except_d = except_q;
        if (pipeline_flush_i) begin
            state_d  = ARB_S;
            valid_d  = 1'b0;
            sel_d    = '0;
            rf_wb_d  = 1'b0;
            except_d = 1'b0;
        end else if (!wb_stall_i) begin
            if (|grant) begin
                valid_d  = 1'b1;
                sel_d    = grant;
                rf_wb_d  = rf_wb_i[g_idx] & ~except_i[g_idx];
                adr_d    = rfd_adr_i[g_idx*A +: A];
                result_d = result_i[g_idx*W +: W];
                except_d = grant_exc;
                if (grant_exc) state_d = HALT_S;
                else           ptr_d   = g_idx;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_S;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
            valid_q  <= 1'b0;
            sel_q    <= '0;
            rf_wb_q  <= 1'b0;
            adr_q    <= '0;
            result_q <= '0;
            except_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            sel_q    <= sel_d;
            rf_wb_q  <= rf_wb_d;
            adr_q    <= adr_d;
            result_q <= result_d;
            except_q <= except_d;
        end
    end

    assign wb_valid_o   = valid_q;
    assign wb_sel_o     = sel_q;
    assign wb_rf_wb_o   = rf_wb_q;
    assign wb_rfd_adr_o = adr_q;
    assign wb_result_o  = result_q;
    assign wb_except_o  = except_q;
    assign halted_o     = (state_q == HALT_S);

endmodule

// File: doc/wb_arbiter_marocchino.md
Name: wb_arbiter_marocchino

Overview:
Shares the single MAROCCHINO register-file write-back port between execution units that complete out of order (1-clk ALU, MUL, DIV, LSU). It selects one requester per cycle by round-robin and acknowledges it with a grant. It registers the winner's result, destination address and write enable into the write-back stage. A request carrying an exception wins immediately and halts further grants until the pipeline is flushed.

Parameters:
OPTION_OPERAND_WIDTH, 32, result width
OPTION_RF_ADDR_WIDTH, 5, RF address width
NUM_REQ, 4, number of requesting units (2..8); index 0=ALU, 1=MUL, 2=DIV, 3=LSU

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pipeline_flush_i  in  1  flush: drop output valid, exit HALT, clear no requests
wb_stall_i  in  1  write-back stage cannot accept; no grant issued
req_i  in  NUM_REQ  per-unit result-ready request
except_i  in  NUM_REQ  per-unit request carries exception
rf_wb_i  in  NUM_REQ  per-unit RF write request
rfd_adr_i  in  NUM_REQ*OPTION_RF_ADDR_WIDTH  packed destination addresses, unit k at [k*A +: A]
result_i  in  NUM_REQ*OPTION_OPERAND_WIDTH  packed results, unit k at [k*W +: W]
grant_o  out  NUM_REQ  one-hot acknowledge, combinational, same cycle as selection
wb_valid_o  out  1  registered: write-back slot holds a granted op
wb_sel_o  out  NUM_REQ  registered one-hot source of current write-back op
wb_rf_wb_o  out  1  registered RF write enable
wb_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  registered destination address
wb_result_o  out  OPTION_OPERAND_WIDTH  registered result
wb_except_o  out  1  registered: granted op carried an exception
halted_o  out  1  arbiter in HALT state

Behaviour:
- Reset: wb_valid_o, wb_sel_o, wb_rf_wb_o, wb_except_o, halted_o = 0. wb_rfd_adr_o, wb_result_o = 0. State ARB. RR pointer = NUM_REQ-1, so unit 0 has first priority.
- States: ARB and HALT.
  - ARB -> HALT when a grant goes to a request with except_i=1.
  - HALT -> ARB on pipeline_flush_i.
  - rst overrides everything, including mid-HALT.
- grant_o is zero when any of these hold: state HALT, wb_stall_i, pipeline_flush_i, or req_i==0.
- Priority order:
  - If any req_i&except_i bit is set, grant the lowest such index, ignoring RR.
  - Otherwise use round-robin: search from pointer+1 upward, wrapping modulo NUM_REQ.
  - Pointer updates to the granted index only for non-exception grants.
- Handshake:
  - A unit holds req_i and its data stable until it sees grant_o.
  - In the cycle after the grant it may drop req_i or present a new op.
  - Back-to-back grants to the same unit are allowed when it is the only requester.
- Latency: the grant cycle N loads the output registers at edge N+1. wb_valid_o=1 for exactly one cycle per grant.
- With no grant and no stall, wb_valid_o <= 0; data registers hold their value. With wb_stall_i=1, all output registers hold.
- pipeline_flush_i: wb_valid_o, wb_rf_wb_o, wb_except_o, wb_sel_o <= 0 and state <= ARB. The pointer is unchanged.
- wb_rf_wb_o = rf_wb_i[g] & ~except_i[g]: an excepting op never writes the RF.
- halted_o = (state==HALT). It rises in the cycle after the exception grant, together with wb_except_o.
- Simultaneous requests from all units under no stall: each is granted within NUM_REQ cycles (starvation-free).

Decomposition:
- Shared package/defines: unit index constants (WB_UNIT_ALU=0, MUL=1, DIV=2, LSU=3), the NUM_REQ default, and state encodings.
- One natural sub-module, rr_pick_marocchino: a combinational round-robin picker with inputs (req, pointer) and a one-hot output, reused by the decode-side issue logic.

Test Plan:
- Reset; req_i=4'b1111, all rf_wb_i=1 -> grants in order 0,1,2,3,0. wb_valid_o=1 each cycle from the first edge after reset release. wb_rfd_adr_o follows each unit's address.
- Only unit 2 requests, held for 3 ops -> grant_o=4'b0100 on 3 consecutive cycles. wb_result_o takes the 3 values one cycle later.
- req_i=4'b1011 and except_i=4'b1000 -> grant_o=4'b1000. Next cycle: wb_except_o=1, wb_rf_wb_o=0, halted_o=1. grant_o stays 0 while req_i=4'b0011 persists.
- In HALT, assert pipeline_flush_i for 1 cycle -> wb_valid_o=0, halted_o=0. The next grant follows the RR pointer preserved from before the exception.
- wb_stall_i=1 for 4 cycles with req_i=4'b0001 -> grant_o=0 and outputs frozen. Grant 4'b0001 occurs in the cycle stall drops.
- rst asserted in HALT with wb_valid_o=1 -> all outputs 0 next cycle. The first grant goes to unit 0 when all units request.
